// File: rtl/sevenseg_pkg.sv
// Shared types, segment glyphs and the gray-decode helper for the scanned
// seven-segment display.
package sevenseg_pkg;

   typedef enum logic [1:0] {
      MODE_HEX     = 2'b00,
      MODE_DEC     = 2'b01,
      MODE_GRAYDEC = 2'b10,
      MODE_GRAYENC = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRAY,
      ST_DABBLE,
      ST_COMMIT
   } state_e;

   localparam int GRAY_MAX_W = 32;

   // Active-high glyphs, bit6=g .. bit0=a
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [6:0] SEG_DASH = 7'b100_0000;

   // Zero-extended inputs decode correctly: leading zeros keep the running XOR at 0
   function automatic logic [GRAY_MAX_W-1:0] gray_decode(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sevenseg_scan_display_if.sv
// Value/control inputs and pin-level outputs of the scanned seven-segment driver.
interface sevenseg_if #(
   parameter int NUM_DIGITS = 4,
   parameter int DATA_W     = 8
);
   logic [DATA_W-1:0]     value;
   logic [1:0]            mode;
   logic                  load;
   logic                  blank_lz;
   logic                  busy;
   logic                  ovf;
   logic [NUM_DIGITS-1:0] anodo;
   logic [6:0]            catodo;
   logic                  dp;

   modport master (
      output value, mode, load, blank_lz,
      input  busy, ovf, anodo, catodo, dp
   );

   modport slave (
      input  value, mode, load, blank_lz,
      output busy, ovf, anodo, catodo, dp
   );
endinterface

// File: rtl/sevenseg_scan_display_bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 step per cycle for DATA_W cycles,
// with one guard nibble and a sticky flag for bits pushed past it.
module bin2bcd_seq #(
   parameter int DATA_W     = 8,
   parameter int NUM_DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_start,
   input  logic [DATA_W-1:0]         i_bin,
   output logic                      o_last,
   output logic [4*NUM_DIGITS+3:0]   o_bcd,
   output logic                      o_spill
);
   localparam int ACC_W = 4*NUM_DIGITS + 4;
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] r_sh;
   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_spill;
   logic [ACC_W-1:0]  w_adj;

   always_comb begin
      w_adj = r_acc;
      for (int k = 0; k < NUM_DIGITS+1; k++) begin
         if (r_acc[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
      end
   end

   // High during the cycle whose closing edge performs the final shift
   assign o_last  = (r_cnt == CNT_W'(1));
   assign o_bcd   = r_acc;
   assign o_spill = r_spill;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_sh    <= i_bin;
         r_acc   <= '0;
         r_spill <= 1'b0;
         r_cnt   <= CNT_W'(DATA_W);
      end else if (r_cnt != '0) begin
         r_acc   <= {w_adj[ACC_W-2:0], r_sh[DATA_W-1]};
         r_sh    <= r_sh << 1;
         r_spill <= r_spill | w_adj[ACC_W-1];
         r_cnt   <= r_cnt - CNT_W'(1);
      end
   end
endmodule

// File: rtl/sevenseg_scan_display.sv
// Captures a value, optionally converts it (gray/BCD) and time-multiplexes it
// across NUM_DIGITS anodes with registered, glitch-free pin outputs.
module sevenseg_scan_display
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS       = 4,
   parameter int DATA_W           = 8,
   parameter int REFRESH_DIV      = 100000,
   parameter int ANODE_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW   = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   sevenseg_if.slave bus
);
   localparam int DISP_W  = 4*NUM_DIGITS;
   localparam int ACC_W   = DISP_W + 4;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRESC_W = $clog2(REFRESH_DIV);
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [6:0]            SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF    = (SEG_ACTIVE_LOW != 0);

   state_e                r_state;
   mode_e                 r_mode;
   logic [DATA_W-1:0]     r_value;
   logic                  r_busy;
   logic                  r_ovf;
   logic [DISP_W-1:0]     r_disp;

   mode_e                 w_mode_in;
   logic                  w_start;
   logic [DATA_W-1:0]     w_bin;
   logic [GRAY_MAX_W-1:0] w_gray_full;
   logic                  w_unused_gray;
   logic                  w_bcd_last;
   logic [ACC_W-1:0]      w_bcd;
   logic                  w_spill;

   assign w_mode_in     = mode_e'(bus.mode);
   assign w_gray_full   = gray_decode(GRAY_MAX_W'(r_value));
   assign w_unused_gray = ^w_gray_full;
   assign w_start = (r_state == ST_GRAY) ||
                    (r_state == ST_IDLE && bus.load && w_mode_in == MODE_DEC);
   assign w_bin   = (r_state == ST_GRAY) ? w_gray_full[DATA_W-1:0] : bus.value;

   bin2bcd_seq #(
      .DATA_W     (DATA_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_start),
      .i_bin   (w_bin),
      .o_last  (w_bcd_last),
      .o_bcd   (w_bcd),
      .o_spill (w_spill)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
         r_disp  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.load) begin
                  r_value <= bus.value;
                  r_mode  <= w_mode_in;
                  r_busy  <= 1'b1;
                  case (w_mode_in)
                     MODE_DEC:     r_state <= ST_DABBLE;
                     MODE_GRAYDEC: r_state <= ST_GRAY;
                     default:      r_state <= ST_COMMIT;
                  endcase
               end
            end
            ST_GRAY:   r_state <= ST_DABBLE;
            ST_DABBLE: if (w_bcd_last) r_state <= ST_COMMIT;
            ST_COMMIT: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
               case (r_mode)
                  MODE_HEX: begin
                     r_disp <= DISP_W'(r_value);
                     r_ovf  <= 1'b0;
                  end
                  MODE_GRAYENC: begin
                     r_disp <= DISP_W'(r_value ^ (r_value >> 1));
                     r_ovf  <= 1'b0;
                  end
                  default: begin
                     r_disp <= w_bcd[DISP_W-1:0];
                     r_ovf  <= (w_bcd[ACC_W-1 -: 4] != 4'd0) || w_spill;
                  end
               endcase
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   logic [PRESC_W-1:0]    r_presc;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_run;
   logic [NUM_DIGITS-1:0] r_anodo;
   logic [6:0]            r_catodo;

   logic                  w_wrap;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [IDX_W-1:0]      w_show_idx;
   logic [NUM_DIGITS-1:0] w_zero_from;
   logic [3:0]            w_nib;
   logic                  w_blank;
   logic [6:0]            w_seg;
   logic [NUM_DIGITS-1:0] w_onehot;

   assign w_wrap     = r_run && (r_presc == PRESC_W'(REFRESH_DIV-1));
   assign w_idx_nxt  = (r_idx == IDX_W'(NUM_DIGITS-1)) ? '0 : r_idx + IDX_W'(1);
   // First cycle out of reset lights digit 0; afterwards outputs move on wrap only
   assign w_show_idx = r_run ? w_idx_nxt : r_idx;
   assign w_onehot   = NUM_DIGITS'(1) << w_show_idx;

   always_comb begin
      logic w_all_zero;
      w_all_zero  = 1'b1;
      w_zero_from = '0;
      for (int k = NUM_DIGITS-1; k >= 0; k--) begin
         w_all_zero     = w_all_zero && (r_disp[4*k +: 4] == 4'd0);
         w_zero_from[k] = w_all_zero;
      end
   end

   always_comb begin
      w_nib   = 4'd0;
      w_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (w_show_idx == IDX_W'(k)) begin
            w_nib   = r_disp[4*k +: 4];
            w_blank = bus.blank_lz && (k != 0) && w_zero_from[k];
         end
      end
   end

   assign w_seg = r_ovf ? SEG_DASH : (w_blank ? 7'h00 : SEG_TABLE[w_nib]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc  <= '0;
         r_idx    <= '0;
         r_run    <= 1'b0;
         r_anodo  <= ANODE_OFF;
         r_catodo <= SEG_OFF;
      end else begin
         r_run <= 1'b1;
         if (r_run) r_presc <= w_wrap ? '0 : r_presc + PRESC_W'(1);
         if (w_wrap) r_idx <= w_idx_nxt;
         if (!r_run || w_wrap) begin
            r_anodo  <= w_onehot ^ ANODE_OFF;
            r_catodo <= w_seg ^ SEG_OFF;
         end
      end
   end

   assign bus.busy   = r_busy;
   assign bus.ovf    = r_ovf;
   assign bus.anodo  = r_anodo;
   assign bus.catodo = r_catodo;
   assign bus.dp     = DP_OFF;
endmodule

// File: tb/tb_sevenseg_scan_display.sv
// Randomized scoreboard bench for sevenseg_scan_display (4-digit and 2-digit builds).
module tb_sevenseg_scan_display;
   localparam int DW  = 8;
   localparam int REF = 4;
   localparam int NDA = 4;
   localparam int NDB = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sevenseg_if #(.NUM_DIGITS(NDA), .DATA_W(DW)) bus_a ();
   sevenseg_if #(.NUM_DIGITS(NDB), .DATA_W(DW)) bus_b ();

   sevenseg_scan_display #(
      .NUM_DIGITS(NDA), .DATA_W(DW), .REFRESH_DIV(REF),
      .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
   ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

   sevenseg_scan_display #(
      .NUM_DIGITS(NDB), .DATA_W(DW), .REFRESH_DIV(REF),
      .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
   ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   typedef struct {
      logic [7:0][6:0] seg;
      bit              ovf;
      int              blen;
      bit              chk_seg;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t q_a[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out, got no event, expected one (t=%0t)", name, $time);
   endtask

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
         3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
         6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
         9: return 7'b1101111; 10: return 7'b1110111; 11: return 7'b1111100;
        12: return 7'b0111001; 13: return 7'b1011110; 14: return 7'b1111001;
         default: return 7'b1110001;
      endcase
   endfunction

   // Reference: what an nd-digit display should show for value/mode/blank
   function automatic exp_t model(input int unsigned v, input int mode, input bit blank, input int nd);
      exp_t        e;
      int unsigned n, s, p10;
      int          dig[8];
      bit          dec, zr;
      n   = v;
      dec = (mode == 1) || (mode == 2);
      if (mode == 3) n = v ^ (v >> 1);
      if (mode == 2) begin
         s = v >> 1;
         while (s != 0) begin n ^= s; s >>= 1; end
      end
      p10 = 1;
      for (int k = 0; k < 8; k++) dig[k] = 0;
      for (int k = 0; k < nd; k++) begin
         dig[k] = dec ? int'((n / p10) % 10) : int'((n >> (4*k)) & 15);
         p10 = p10 * 10;
      end
      e.ovf     = dec && (n >= p10);
      e.blen    = (mode == 1) ? DW + 1 : (mode == 2) ? DW + 2 : 1;
      e.chk_seg = 1'b1;
      e.seg     = '0;
      zr        = 1'b1;
      for (int k = nd-1; k >= 0; k--) begin
         zr = zr && (dig[k] == 0);
         if (e.ovf)                    e.seg[k] = 7'b1000000;
         else if (blank && k > 0 && zr) e.seg[k] = 7'b0000000;
         else                          e.seg[k] = glyph(dig[k]);
      end
      return e;
   endfunction

   // Sample every digit once, starting at the next slot boundary
   task automatic observe_a(input logic [7:0][6:0] es, input string tag);
      logic [NDA-1:0] prev;
      logic [6:0]     want;
      int             g, idx;
      prev = bus_a.anodo;
      for (int s = 0; s < NDA; s++) begin
         g = 0;
         while (bus_a.anodo == prev && g < 4*REF) begin @(negedge clk); g++; end
         if (g >= 4*REF) begin timeout({tag, "_slot"}); return; end
         prev = bus_a.anodo;
         idx  = 0;
         for (int j = 0; j < NDA; j++) if (!prev[j]) idx = j;
         want = ~es[idx];
         chk($sformatf("%s_digit%0d", tag, idx), 32'(bus_a.catodo), 32'(want));
      end
      chk({tag, "_dp"}, 32'(bus_a.dp), 32'd1);
   endtask

   task automatic observe_b(input logic [7:0][6:0] es, input string tag);
      logic [NDB-1:0] prev;
      logic [6:0]     want;
      int             g, idx;
      prev = bus_b.anodo;
      for (int s = 0; s < NDB; s++) begin
         g = 0;
         while (bus_b.anodo == prev && g < 4*REF) begin @(negedge clk); g++; end
         if (g >= 4*REF) begin timeout({tag, "_slot"}); return; end
         prev = bus_b.anodo;
         idx  = 0;
         for (int j = 0; j < NDB; j++) if (!prev[j]) idx = j;
         want = ~es[idx];
         chk($sformatf("%s_digit%0d", tag, idx), 32'(bus_b.catodo), 32'(want));
      end
   endtask

   // Scoreboard monitor for DUT A: each busy fall is a commit
   initial begin : mon_a
      int   blen;
      bit   pb;
      exp_t e;
      blen = 0;
      pb   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            blen = 0;
            pb   = 1'b0;
         end else begin
            if (bus_a.busy) blen++;
            else if (pb) begin
               if (q_a.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_commit: got a commit, expected none (t=%0t)", $time);
               end else begin
                  e = q_a.pop_front();
                  chk("busy_len", 32'(blen), 32'(e.blen));
                  chk("ovf", 32'(bus_a.ovf), 32'(e.ovf));
                  if (e.chk_seg) observe_a(e.seg, "disp");
               end
               blen = 0;
            end
            pb = bus_a.busy;
         end
      end
   end

   // Scan rotation checker for DUT A
   initial begin : scan_a
      int             dwell, idx, nidx;
      int             state;
      logic [NDA-1:0] pa;
      state = 0;
      dwell = 0;
      idx   = 0;
      pa    = '1;
      forever begin
         @(negedge clk);
         if (!rst_n) state = 0;
         else if (state == 0) state = 1;
         else if (state == 1) begin
            chk("first_anode", 32'(bus_a.anodo), 32'(4'b1110));
            pa    = bus_a.anodo;
            idx   = 0;
            dwell = 1;
            state = 2;
         end else begin
            chk("anode_onehot", 32'($onehot(~bus_a.anodo)), 32'd1);
            if (bus_a.anodo != pa) begin
               nidx = 0;
               for (int j = 0; j < NDA; j++) if (!bus_a.anodo[j]) nidx = j;
               chk("scan_next", 32'(nidx), 32'((idx + 1) % NDA));
               chk("scan_dwell", 32'(dwell), 32'(REF));
               idx   = nidx;
               pa    = bus_a.anodo;
               dwell = 1;
            end else begin
               dwell++;
               if (dwell > REF) chk("scan_stall", 32'(dwell), 32'(REF));
            end
         end
      end
   end

   task automatic load_a(input int unsigned v, input int m, input bit bl, input bit cs, input bit push);
      exp_t e;
      bus_a.value    = v[7:0];
      bus_a.mode     = m[1:0];
      bus_a.blank_lz = bl;
      bus_a.load     = 1'b1;
      if (push) begin
         e         = model(v, m, bl, NDA);
         e.chk_seg = cs;
         q_a.push_back(e);
      end
      @(posedge clk); #1;
      bus_a.load = 1'b0;
   endtask

   task automatic wait_idle_a();
      int g;
      g = 0;
      while (bus_a.busy && g < 40) begin @(posedge clk); #1; g++; end
      if (g >= 40) timeout("a_busy_clear");
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic txn_a(input int unsigned v, input int m, input bit bl);
      load_a(v, m, bl, 1'b1, 1'b1);
      wait_idle_a();
      settle(6*REF + 4);
   endtask

   task automatic txn_b(input int unsigned v, input int m, input bit bl);
      exp_t e;
      int   g;
      e = model(v, m, bl, NDB);
      bus_b.value    = v[7:0];
      bus_b.mode     = m[1:0];
      bus_b.blank_lz = bl;
      bus_b.load     = 1'b1;
      @(posedge clk); #1;
      bus_b.load = 1'b0;
      g = 0;
      while (bus_b.busy && g < 40) begin @(posedge clk); #1; g++; end
      if (g >= 40) timeout("b_busy_clear");
      chk("b_ovf", 32'(bus_b.ovf), 32'(e.ovf));
      @(negedge clk);
      observe_b(e.seg, "b_disp");
      settle(2);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int unsigned v;
      int          m;
      bit          bl;
      exp_t        ez;
      bus_a.value = '0; bus_a.mode = '0; bus_a.load = 1'b0; bus_a.blank_lz = 1'b0;
      bus_b.value = '0; bus_b.mode = '0; bus_b.load = 1'b0; bus_b.blank_lz = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus_a.busy), 32'd0);
      chk("rst_ovf", 32'(bus_a.ovf), 32'd0);
      chk("rst_anodo", 32'(bus_a.anodo), 32'hF);
      chk("rst_catodo", 32'(bus_a.catodo), 32'h7F);
      chk("rst_dp", 32'(bus_a.dp), 32'd1);
      chk("rst_b_anodo", 32'(bus_b.anodo), 32'h3);
      @(posedge clk); #1;
      rst_n = 1'b1;
      settle(2);

      txn_a(255, 1, 1'b0);
      txn_a(255, 1, 1'b1);
      txn_a(8'h80, 2, 1'b0);
      txn_a(8'h0F, 3, 1'b0);
      txn_a(8'h00, 0, 1'b1);
      txn_a(8'h07, 0, 1'b1);

      // load during busy is dropped
      load_a(200, 1, 1'b0, 1'b1, 1'b1);
      settle(3);
      load_a(7, 0, 1'b0, 1'b0, 1'b0);
      wait_idle_a();
      settle(6*REF + 4);

      // load accepted in the cycle busy falls
      load_a(8'h12, 0, 1'b0, 1'b0, 1'b1);
      wait_idle_a();
      load_a(8'hA5, 3, 1'b0, 1'b1, 1'b1);
      wait_idle_a();
      settle(6*REF + 4);

      for (int i = 0; i < 24; i++) begin
         v  = $urandom_range(0, 255);
         m  = int'($urandom_range(0, 3));
         bl = 1'($urandom_range(0, 1));
         txn_a(v, m, bl);
      end

      // reset in the middle of a conversion leaves a zero display
      txn_a(8'h00, 0, 1'b0);
      load_a(99, 1, 1'b0, 1'b0, 1'b0);
      settle(4);
      rst_n = 1'b0;
      settle(2);
      rst_n = 1'b1;
      settle(1);
      chk("abort_busy", 32'(bus_a.busy), 32'd0);
      settle(DW + 4);
      chk("abort_busy_late", 32'(bus_a.busy), 32'd0);
      chk("abort_ovf", 32'(bus_a.ovf), 32'd0);
      chk("abort_queue", 32'(q_a.size()), 32'd0);
      ez = model(0, 0, 1'b0, NDA);
      @(negedge clk);
      observe_a(ez.seg, "abort_disp");
      settle(2);

      txn_b(100, 1, 1'b0);
      txn_b(8'h3C, 0, 1'b0);
      txn_b(99, 1, 1'b1);
      txn_b(8'h80, 2, 1'b0);
      txn_b(5, 1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         v  = $urandom_range(0, 255);
         m  = int'($urandom_range(0, 3));
         bl = 1'($urandom_range(0, 1));
         txn_b(v, m, bl);
      end

      chk("queue_drained", 32'(q_a.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
